// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, grant-source encoding and a register-decode helper for the
// register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 32;
    localparam int REG_ZERO   = 0;

    // Which writer owns the registered rf_* write this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_A,
        SRC_B
    } wb_src_e;

    function automatic logic [31:0] reg_bit(input int unsigned idx);
        return (idx < 32) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline-writeback, load-return and register-file signals.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) ();
    logic              a_valid;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AWIDTH-1:0] b_addr;
    logic [DWIDTH-1:0] b_data;
    logic              rf_we;
    logic [AWIDTH-1:0] rf_wa;
    logic [DWIDTH-1:0] rf_wd;
    logic [31:0]       pend_mask;
    logic              stall_req;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  b_ready, rf_we, rf_wa, rf_wd, pend_mask, stall_req
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output b_ready, rf_we, rf_wa, rf_wd, pend_mask, stall_req
    );
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Load-return FIFO with a per-entry live bit; a kill port retires entries whose
// destination is overwritten by a younger pipeline write.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [AWIDTH-1:0]            push_addr,
    input  logic [DWIDTH-1:0]            push_data,
    input  logic                         pop,
    input  logic                         kill_en,
    input  logic [AWIDTH-1:0]            kill_addr,
    output logic                         full,
    output logic                         empty,
    output logic                         head_live,
    output logic [AWIDTH-1:0]            head_addr,
    output logic [DWIDTH-1:0]            head_data,
    output logic [DEPTH-1:0]             entry_live,
    output logic [DEPTH-1:0][AWIDTH-1:0] entry_addr
);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);

    logic [PW:0]                  wr_ptr, rd_ptr;
    logic [PW-1:0]                wr_idx, rd_idx;
    logic [DEPTH-1:0][AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0]            mem_data [DEPTH];
    logic [DEPTH-1:0]             live;
    logic                         push_live;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

    // An arriving entry is already dead if it targets x0 or the same-cycle A write.
    assign push_live = (push_addr != AWIDTH'(REG_ZERO)) && !(kill_en && (kill_addr == push_addr));

    // NOTE: state registers use non-blocking assignments so later statements in
    // this block (kill, then pop, then push) see pre-edge values and the last
    // assignment to a live bit wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            live   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem_addr[i] == kill_addr)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_idx] <= 1'b0;
                rd_ptr       <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                live[wr_idx] <= push_live;
                wr_ptr       <= wr_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: payload storage has no reset; the live bits and pointers alone
    // decide what is valid, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_idx] <= push_addr;
            mem_data[wr_idx] <= push_data;
        end
    end

    assign head_live  = live[rd_idx];
    assign head_addr  = mem_addr[rd_idx];
    assign head_data  = mem_data[rd_idx];
    assign entry_live = live;
    assign entry_addr = mem_addr;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority, load
// returns (B) are queued, tracked in pend_mask and protected from starvation.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int          CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic                         full, empty, head_live;
    logic [AWIDTH-1:0]            head_addr;
    logic [DWIDTH-1:0]            head_data;
    logic [DEPTH-1:0]             entry_live;
    logic [DEPTH-1:0][AWIDTH-1:0] entry_addr;
    logic                         push, pop, a_win, b_grant;
    logic [CW-1:0]                wait_cnt, wait_next;
    logic                         stall_q;
    wb_src_e                      rf_src;
    logic [AWIDTH-1:0]            rf_wa_q;
    logic [DWIDTH-1:0]            rf_wd_q;
    logic [31:0]                  pend;

    assign a_win   = bus.a_valid && (bus.a_addr != AWIDTH'(REG_ZERO));
    assign b_grant = head_live && !a_win;
    // Dead heads drain every cycle, independent of who owns the write port.
    assign pop     = !empty && (!head_live || b_grant);
    assign push    = bus.b_valid && !full;

    wb_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (bus.b_addr),
        .push_data  (bus.b_data),
        .pop        (pop),
        .kill_en    (a_win),
        .kill_addr  (bus.a_addr),
        .full       (full),
        .empty      (empty),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .entry_live (entry_live),
        .entry_addr (entry_addr)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        wait_next = wait_cnt;
        if (!head_live || b_grant) wait_next = '0;
        else if (wait_cnt != LIMIT) wait_next = wait_cnt + ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_src   <= SRC_NONE;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            // Also drop the stall if nothing live remains, so it cannot stick.
            if (b_grant || (entry_live == '0)) stall_q <= 1'b0;
            else if (wait_next == LIMIT) stall_q <= 1'b1;
            if (a_win) begin
                rf_src  <= SRC_A;
                rf_wa_q <= bus.a_addr;
                rf_wd_q <= bus.a_data;
            end else if (b_grant) begin
                rf_src  <= SRC_B;
                rf_wa_q <= head_addr;
                rf_wd_q <= head_data;
            end else begin
                rf_src  <= SRC_NONE;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i]) pend = pend | reg_bit(32'(entry_addr[i]));
        end
        if (rf_src == SRC_B) pend = pend | reg_bit(32'(rf_wa_q));
        pend[0] = 1'b0;
    end

    assign bus.b_ready   = !full;
    assign bus.rf_we     = (rf_src != SRC_NONE);
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.pend_mask = pend;
    assign bus.stall_req = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed vector table, asynchronous-reset sequence and
// random traffic against a queue-based reference model.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    rf_wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          a_v;
        logic [AW-1:0] a_a;
        logic [DW-1:0] a_d;
        logic          b_v;
        logic [AW-1:0] b_a;
        logic [DW-1:0] b_d;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [31:0]   pend;
        logic          ready;
        logic          stall;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } ent_t;

    vec_t vecs[$];

    // Reference model state
    ent_t          mq[$];
    bit            m_we, m_from_b, m_stall;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                                input logic b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d,
                                input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [31:0] pend, input logic ready, input logic stall);
        vec_t v;
        v.a_v = a_v; v.a_a = a_a; v.a_d = a_d;
        v.b_v = b_v; v.b_a = b_a; v.b_d = b_d;
        v.we = we; v.wa = wa; v.wd = wd;
        v.pend = pend; v.ready = ready; v.stall = stall;
        return v;
    endfunction

    task automatic drive(input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                         input logic b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d);
        bus.a_valid = a_v; bus.a_addr = a_a; bus.a_data = a_d;
        bus.b_valid = b_v; bus.b_addr = b_a; bus.b_data = b_d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [31:0] pend,
                                 input logic ready, input logic stall);
        check($sformatf("%s rf_we", tag), bus.rf_we, we);
        if (we) begin
            check($sformatf("%s rf_wa", tag), bus.rf_wa, wa);
            check($sformatf("%s rf_wd", tag), bus.rf_wd, wd);
        end
        check($sformatf("%s pend_mask", tag), bus.pend_mask, pend);
        check($sformatf("%s b_ready", tag), bus.b_ready, ready);
        check($sformatf("%s stall_req", tag), bus.stall_req, stall);
    endtask

    task automatic check_reset_values(input string tag);
        check_outputs(tag, 1'b0, '0, '0, 32'd0, 1'b1, 1'b0);
        check($sformatf("%s rf_wa reset", tag), bus.rf_wa, 0);
        check($sformatf("%s rf_wd reset", tag), bus.rf_wd, 0);
    endtask

    task automatic apply_row(input vec_t v, input string tag);
        drive(v.a_v, v.a_a, v.a_d, v.b_v, v.b_a, v.b_d);
        tick();
        check_outputs(tag, v.we, v.wa, v.wd, v.pend, v.ready, v.stall);
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p = p | (32'd1 << mq[i].addr);
        if (m_we && m_from_b) p = p | (32'd1 << m_wa);
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_we = 0; m_from_b = 0; m_stall = 0; m_wait = 0;
        m_wa = '0; m_wd = '0;
    endtask

    // One cycle of the ordering/priority rules applied to the model queue.
    task automatic m_step(input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                          input logic b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d);
        bit   a_win, any_live, head_live, b_grant, can_push;
        ent_t e;
        a_win     = a_v && (a_a != 0);
        any_live  = 0;
        foreach (mq[i]) if (mq[i].live) any_live = 1;
        head_live = (mq.size() > 0) && mq[0].live;
        b_grant   = head_live && !a_win;
        can_push  = b_v && (mq.size() < DEPTH);
        if (a_win) begin
            m_we = 1; m_from_b = 0; m_wa = a_a; m_wd = a_d;
        end else if (b_grant) begin
            m_we = 1; m_from_b = 1; m_wa = mq[0].addr; m_wd = mq[0].data;
        end else begin
            m_we = 0; m_from_b = 0;
        end
        if ((mq.size() > 0) && (!mq[0].live || b_grant)) void'(mq.pop_front());
        if (a_win) foreach (mq[i]) if (mq[i].addr == a_a) mq[i].live = 0;
        if (can_push) begin
            e.addr = b_a; e.data = b_d;
            e.live = (b_a != 0) && !(a_win && (a_a == b_a));
            mq.push_back(e);
        end
        if (!head_live || b_grant) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
        if (b_grant || !any_live) m_stall = 0;
        else if (m_wait == LIMIT) m_stall = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          r_av, r_bv, b_hold, ready_now;
        logic [AW-1:0] r_aa, r_ba;
        logic [DW-1:0] r_ad, r_bd;

        drive(0, '0, '0, 0, '0, '0);
        repeat (2) tick();
        check_reset_values("in_reset");
        rst = 1'b1;
        tick();
        check_reset_values("after_release");

        // Directed table: inputs for one cycle, outputs expected after that edge.
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 5, 32'hDEADBEEF, 32'h0,  1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 7, 32'h11, 0, 0, 0,            32'h80, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 7, 32'h11,       32'h80, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(1, 6, 32'h22,       1, 6, 32'h33, 1, 6, 32'h22,       32'h0,  1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(1, 0, 32'h55,       1, 0, 32'h44, 0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        vecs.push_back(mk(1, 9, 32'h90,       1, 3, 32'h03, 1, 9, 32'h90,       32'h08, 1, 0));
        vecs.push_back(mk(1, 9, 32'h91,       1, 4, 32'h04, 1, 9, 32'h91,       32'h18, 0, 0));
        vecs.push_back(mk(1, 9, 32'h92,       0, 0, 0,      1, 9, 32'h92,       32'h18, 0, 0));
        vecs.push_back(mk(1, 9, 32'h93,       0, 0, 0,      1, 9, 32'h93,       32'h18, 0, 0));
        vecs.push_back(mk(1, 9, 32'h94,       0, 0, 0,      1, 9, 32'h94,       32'h18, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 3, 32'h03,       32'h18, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 4, 32'h04,       32'h10, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            32'h0,  1, 0));
        for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset with two live entries queued and stall_req high.
        apply_row(mk(1, 9, 32'hA0, 1, 3, 32'h30, 1, 9, 32'hA0, 32'h08, 1, 0), "rst_seq0");
        apply_row(mk(1, 9, 32'hA1, 1, 4, 32'h40, 1, 9, 32'hA1, 32'h18, 0, 0), "rst_seq1");
        for (int i = 2; i < 5; i++)
            apply_row(mk(1, 9, 32'hA0 + 32'(i), 0, 0, 0, 1, 9, 32'hA0 + 32'(i), 32'h18, 0, (i == 4)),
                      $sformatf("rst_seq%0d", i));
        drive(0, '0, '0, 0, '0, '0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outputs($sformatf("post_reset%0d", i), 1'b0, '0, '0, 32'd0, 1'b1, 1'b0);
        end

        // Random traffic against the reference model.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_reset();
        b_hold = 0;
        r_bv = 0; r_ba = '0; r_bd = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            check_outputs($sformatf("rand%0d", cyc), m_we, m_wa, m_wd, m_pend(),
                          (mq.size() < DEPTH), m_stall);
            ready_now = (mq.size() < DEPTH);
            if (!b_hold) begin
                r_bv = ($urandom_range(0, 2) == 0);
                r_ba = AW'($urandom_range(0, 7));
                r_bd = $urandom;
            end
            r_av = !m_stall && ($urandom_range(0, 1) == 0);
            r_aa = AW'($urandom_range(0, 7));
            r_ad = $urandom;
            drive(r_av, r_aa, r_ad, r_bv, r_ba, r_bd);
            m_step(r_av, r_aa, r_ad, r_bv, r_ba, r_bd);
            b_hold = r_bv && !ready_now;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port (we/wa/wd) in the decode stage.
- Shares it between two writers:
  - Port A: in-order pipeline writeback. Always accepted, highest priority.
  - Port B: long-latency load/MMIO returns. Valid/ready, buffered in a DEPTH-entry FIFO.
- Provides a pending-write mask so decode can stall on registers awaiting a B write.
- Raises stall_req when B is starved.

Parameters:
- DWIDTH, 32, register data width.
- AWIDTH, 5, register address width.
- DEPTH, 2, B FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles a live B head may wait before stall_req asserts (≥1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  pipeline writeback request this cycle.
- a_addr  in  AWIDTH  pipeline rd.
- a_data  in  DWIDTH  pipeline write data.
- b_valid  in  1  load return valid.
- b_ready  out  1  FIFO can accept a B entry.
- b_addr  in  AWIDTH  load rd.
- b_data  in  DWIDTH  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_wa  out  AWIDTH  register-file write address (registered).
- rf_wd  out  DWIDTH  register-file write data (registered).
- pend_mask  out  32  bit i = a B write to xi is outstanding.
- stall_req  out  1  pipeline must hold a_valid low until deasserted.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, wait_cnt=0.
  - rf_we=0, rf_wa=0, rf_wd=0, pend_mask=0, stall_req=0, b_ready=1.
  - Reset mid-operation discards all queued B entries; no write issues.
- Handshake:
  - b_ready = !full; it does not depend on pop in the same cycle.
  - Enqueue on b_valid & b_ready at the edge.
  - b_valid/b_addr/b_data must stay stable while b_ready=0.
- Ordering rule: every B entry, queued or arriving, is older than any concurrent or later A write.
  - A write to xN (N≠0) kills all live FIFO entries with addr N, including an entry enqueued the same cycle.
  - Killed entries pop without writing.
- Grant (per cycle, combinational, registered into rf_*):
  - A wins if a_valid & a_addr≠0.
  - Otherwise B wins if the FIFO head is live.
  - A dead head pops in any cycle regardless of the A grant; the next entry becomes head next cycle.
  - x0 writes never assert rf_we. A B entry to x0 is enqueued then dropped as dead.
- Latency:
  - A request in cycle N → rf_we/rf_wa/rf_wd valid in cycle N+1.
  - B enqueued at edge N → earliest grant cycle N+1 → rf_we in cycle N+2.
- pend_mask:
  - OR of live FIFO entries' decoded addresses, plus rf_wa when rf_we came from B.
  - Bit 0 is always 0.
- Starvation:
  - wait_cnt increments each cycle a live head is not granted.
  - wait_cnt clears on B grant or when no live head exists.
  - When wait_cnt reaches STARVE_LIMIT, stall_req is registered high. It stays high until the cycle after a B grant.
  - a_valid while stall_req=1 is a contract violation. A still wins (no data loss) and wait_cnt saturates.
- Full + simultaneous: with FIFO full, b_ready=0 even if the head pops this cycle. Space reappears the next cycle.

Decomposition:
- Shared defines header: AWIDTH, REG_ZERO (5'd0), DWIDTH default.
- One sub-module, wb_fifo. It holds the DEPTH-entry sync FIFO with per-entry live bit, a kill-compare port (addr, en), and a per-entry addr output for pend_mask.
- rf_wb_arbiter holds grant, output register, and starvation counter.

Test Plan:
- Reset release, idle, a_valid=1 a_addr=5 a_data=0xDEADBEEF → next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. Before that cycle rf_we=0, b_ready=1.
- b_valid pulse with b_addr=7 b_data=0x11, A idle → pend_mask[7]=1 the next cycle; rf_we with wa=7 wd=0x11 two cycles after enqueue; pend_mask clears after the write cycle.
- Fill the FIFO with B addrs 3 and 4 while A writes x9 every cycle → b_ready=0. stall_req rises after 4 ungranted cycles. Drop a_valid → x3 written, stall_req falls next cycle, then x4 written.
- Queue B addr 6, same cycle A writes x6=0x22 → rf_wd=0x22 once. The B entry is killed, never written, and pend_mask[6] never remains set after the kill cycle.
- B write to x0 and A write to x0 → rf_we stays 0, pend_mask[0]=0, FIFO drains.
- Assert rst with 2 live B entries and stall_req=1 → all outputs at reset values immediately (asynchronous). No rf_we after release.
